rpn_sequencer: RTL and testbench

//  Controller sitting between the PS/2 scan-code decoder and VGA_Text.

---
 rtl/rpn_sequencer_pkg.sv | 51 +++++
 rtl/rpn_sequencer_bcd_digit_adder.sv | 38 +++
 rtl/rpn_sequencer.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_rpn_sequencer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rpn_sequencer_pkg.sv
// Shared constants for the RPN calculator sequencer: PS/2 make codes, ASCII
// glyphs, FSM state encoding and result codes.
package rpn_sequencer_pkg;

   localparam logic [7:0] KC_BKSP     = 8'h66;
   localparam logic [7:0] KC_ENTER    = 8'h5A;
   localparam logic [7:0] KC_ESC      = 8'h76;
   localparam logic [7:0] KC_PLUS_KP  = 8'h79;
   localparam logic [7:0] KC_PLUS     = 8'h55;
   localparam logic [7:0] KC_MINUS_KP = 8'h7B;
   localparam logic [7:0] KC_MINUS    = 8'h4E;

   localparam logic [7:0] ASCII_ZERO  = 8'h30;
   localparam logic [7:0] ASCII_SPACE = 8'h20;
   localparam logic [7:0] ASCII_QMARK = 8'h3F;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARITH   = 2'd1,
      ST_EMIT    = 2'd2,
      ST_NEWLINE = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      ERR_OK    = 2'd0,
      ERR_FULL  = 2'd1,
      ERR_UNDER = 2'd2,
      ERR_CARRY = 2'd3
   } err_t;

   // {hit, bcd digit} for the top-row number keys
   function automatic logic [4:0] decode_digit(input logic [7:0] code);
      logic [4:0] r;
      r = '0;
      case (code)
         8'h45:   r = {1'b1, 4'd0};
         8'h16:   r = {1'b1, 4'd1};
         8'h1E:   r = {1'b1, 4'd2};
         8'h26:   r = {1'b1, 4'd3};
         8'h25:   r = {1'b1, 4'd4};
         8'h2E:   r = {1'b1, 4'd5};
         8'h36:   r = {1'b1, 4'd6};
         8'h3D:   r = {1'b1, 4'd7};
         8'h3E:   r = {1'b1, 4'd8};
         8'h46:   r = {1'b1, 4'd9};
         default: r = '0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/rpn_sequencer_bcd_digit_adder.sv
// One BCD digit of add or subtract with carry/borrow in and out.
// Subtract yields the ten's-complement digit when a borrow is produced.
module rpn_sequencer_bcd_digit_adder (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   input  logic       sub,
   output logic [3:0] d,
   output logic       cout
);

   logic [4:0] sum_raw;
   logic [4:0] dif_raw;
   logic [3:0] sum_adj;
   logic [3:0] dif_adj;

   assign sum_raw = {1'b0, a} + {1'b0, b} + {4'b0, cin};
   assign dif_raw = {1'b0, a} - {1'b0, b} - {4'b0, cin};
   // -10 and +10 modulo 16 on the low nibble
   assign sum_adj = sum_raw[3:0] + 4'd6;
   assign dif_adj = dif_raw[3:0] + 4'd10;

   always_comb begin
      d    = sum_raw[3:0];
      cout = 1'b0;
      if (sub) begin
         d = dif_raw[3:0];
         if (dif_raw[4]) begin
            d    = dif_adj;
            cout = 1'b1;
         end
      end else if (sum_raw > 5'd9) begin
         d    = sum_adj;
         cout = 1'b1;
      end
   end

endmodule

// File: rtl/rpn_sequencer.sv
// Keyboard-driven RPN calculator controller: builds BCD operands, runs the
// operand stack with nibble-serial add/subtract and echoes text to VGA_Text.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// ST_IDLE    | Key_Ready high; digits, backspace and commands handled here
// ST_ARITH   | one BCD digit per cycle, LS first, carry/borrow rippled
// ST_EMIT    | result scanned MS first, leading zeros suppressed
// ST_NEWLINE | cursor to column 0 of the next line, then back to IDLE
module rpn_sequencer
   import rpn_sequencer_pkg::*;
#(
   parameter int DEPTH  = 8,
   parameter int DIGITS = 8,
   parameter int COLS   = 64,
   parameter int ROWS   = 30
) (
   input  logic       CLK_25M,
   input  logic       Reset_n,
   input  logic       Key_Valid,
   input  logic [7:0] Key_Code,
   input  logic       Key_Ext,
   output logic       Key_Ready,
   output logic [4:0] Line,
   output logic [6:0] Character,
   output logic [7:0] Glyph,
   output logic       Latch,
   output logic [1:0] Err_Code,
   output logic [3:0] Depth
);

   localparam int W      = 4 * DIGITS;
   localparam int IDX_W  = $clog2(DEPTH);
   localparam int CNT_W  = $clog2(DIGITS + 1);
   localparam int STEP_W = $clog2(DIGITS);

   localparam logic [3:0]        SP_FULL   = 4'(DEPTH);
   localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DIGITS);
   localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(DIGITS - 1);
   localparam logic [4:0]        LINE_LAST = 5'(ROWS - 1);
   localparam logic [6:0]        COL_LAST  = 7'(COLS - 1);

   state_t            state_q, state_d;
   err_t              err_q, err_d;
   logic [3:0]        sp_q, sp_d;
   logic [W-1:0]      entry_q, entry_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [W-1:0]      stack_q [DEPTH];
   logic [W-1:0]      stack_d [DEPTH];
   logic [W-1:0]      opa_q, opa_d;
   logic [W-1:0]      opb_q, opb_d;
   logic [W-1:0]      res_q, res_d;
   logic              carry_q, carry_d;
   logic              sub_q, sub_d;
   logic [STEP_W-1:0] step_q, step_d;
   logic              started_q, started_d;
   logic [4:0]        cur_line_q, cur_line_d;
   logic [6:0]        cur_col_q, cur_col_d;
   logic [4:0]        line_q, line_d;
   logic [6:0]        char_q, char_d;
   logic [7:0]        glyph_q, glyph_d;
   logic              latch_q, latch_d;

   logic             key_acc;
   logic [4:0]       dig_dec;
   logic             dig_hit;
   logic             is_plus, is_minus;
   logic             pend;
   logic [IDX_W-1:0] idx_m1, idx_m2;
   logic [3:0]       nib_sum;
   logic             nib_cout;
   logic [3:0]       emit_nib;
   logic [11:0]      cur_adv;

   function automatic logic [4:0] next_line(input logic [4:0] l);
      return (l == LINE_LAST) ? 5'd0 : l + 5'd1;
   endfunction

   rpn_sequencer_bcd_digit_adder u_digit (
      .a    (opa_q[3:0]),
      .b    (opb_q[3:0]),
      .cin  (carry_q),
      .sub  (sub_q),
      .d    (nib_sum),
      .cout (nib_cout)
   );

   assign key_acc  = Key_Valid & (state_q == ST_IDLE);
   assign dig_dec  = decode_digit(Key_Code);
   assign dig_hit  = dig_dec[4] & ~Key_Ext;
   assign is_plus  = (Key_Code == KC_PLUS_KP) || (Key_Code == KC_PLUS);
   assign is_minus = (Key_Code == KC_MINUS_KP) || (Key_Code == KC_MINUS);
   assign pend     = (cnt_q != '0);
   assign idx_m1   = IDX_W'(sp_q - 4'd1);
   assign idx_m2   = IDX_W'(sp_q - 4'd2);
   assign emit_nib = res_q[W-1 -: 4];
   assign cur_adv  = (cur_col_q == COL_LAST) ? {next_line(cur_line_q), 7'd0}
                                             : {cur_line_q, cur_col_q + 7'd1};

   always_comb begin
      state_d    = state_q;
      err_d      = err_q;
      sp_d       = sp_q;
      entry_d    = entry_q;
      cnt_d      = cnt_q;
      stack_d    = stack_q;
      opa_d      = opa_q;
      opb_d      = opb_q;
      res_d      = res_q;
      carry_d    = carry_q;
      sub_d      = sub_q;
      step_d     = step_q;
      started_d  = started_q;
      cur_line_d = cur_line_q;
      cur_col_d  = cur_col_q;
      line_d     = line_q;
      char_d     = char_q;
      glyph_d    = glyph_q;
      latch_d    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (key_acc) begin
               if (dig_hit) begin
                  if (cnt_q != CNT_FULL) begin
                     entry_d                 = {entry_q[W-5:0], dig_dec[3:0]};
                     cnt_d                   = cnt_q + 1'b1;
                     latch_d                 = 1'b1;
                     line_d                  = cur_line_q;
                     char_d                  = cur_col_q;
                     glyph_d                 = ASCII_ZERO | {4'h0, dig_dec[3:0]};
                     {cur_line_d, cur_col_d} = cur_adv;
                  end
               end else if (Key_Code == KC_BKSP && !Key_Ext) begin
                  if (pend) begin
                     entry_d   = entry_q >> 4;
                     cnt_d     = cnt_q - 1'b1;
                     cur_col_d = (cur_col_q == 7'd0) ? 7'd0 : cur_col_q - 7'd1;
                     latch_d   = 1'b1;
                     line_d    = cur_line_q;
                     char_d    = cur_col_d;
                     glyph_d   = ASCII_SPACE;
                  end
               end else if (Key_Code == KC_ENTER && !Key_Ext) begin
                  if (sp_q != SP_FULL) begin
                     stack_d[sp_q[IDX_W-1:0]] = entry_q;
                     sp_d    = sp_q + 4'd1;
                     entry_d = '0;
                     cnt_d   = '0;
                     err_d   = ERR_OK;
                  end else begin
                     err_d = ERR_FULL;
                  end
                  state_d = ST_NEWLINE;
               end else if (Key_Code == KC_ESC && !Key_Ext) begin
                  sp_d    = 4'd0;
                  entry_d = '0;
                  cnt_d   = '0;
                  err_d   = ERR_OK;
                  state_d = ST_NEWLINE;
               end else if (is_plus || is_minus) begin
                  sub_d = is_minus;
                  if (pend && sp_q == SP_FULL) begin
                     err_d   = ERR_FULL;
                     state_d = ST_NEWLINE;
                  end else begin
                     if (pend) begin
                        stack_d[sp_q[IDX_W-1:0]] = entry_q;
                        sp_d    = sp_q + 4'd1;
                        entry_d = '0;
                        cnt_d   = '0;
                     end
                     if (sp_d < 4'd2) begin
                        err_d   = ERR_UNDER;
                        latch_d = 1'b1;
                        line_d  = cur_line_q;
                        char_d  = cur_col_q;
                        glyph_d = ASCII_QMARK;
                        state_d = ST_NEWLINE;
                     end else begin
                        // a pending entry becomes B directly; stack_q is not yet updated
                        opb_d   = pend ? entry_q : stack_q[idx_m1];
                        opa_d   = pend ? stack_q[idx_m1] : stack_q[idx_m2];
                        res_d   = '0;
                        carry_d = 1'b0;
                        step_d  = STEP_LAST;
                        state_d = ST_ARITH;
                     end
                  end
               end
            end
         end

         ST_ARITH: begin
            opa_d   = opa_q >> 4;
            opb_d   = opb_q >> 4;
            carry_d = nib_cout;
            res_d   = {nib_sum, res_q[W-1:4]};
            step_d  = step_q - 1'b1;
            if (step_q == '0) begin
               stack_d[idx_m2] = res_d;
               sp_d            = sp_q - 4'd1;
               err_d           = nib_cout ? ERR_CARRY : ERR_OK;
               cur_line_d      = next_line(cur_line_q);
               cur_col_d       = 7'd0;
               step_d          = STEP_LAST;
               started_d       = 1'b0;
               state_d         = ST_EMIT;
            end
         end

         ST_EMIT: begin
            res_d  = res_q << 4;
            step_d = step_q - 1'b1;
            if (emit_nib != 4'd0 || started_q || step_q == '0) begin
               started_d               = 1'b1;
               latch_d                 = 1'b1;
               line_d                  = cur_line_q;
               char_d                  = cur_col_q;
               glyph_d                 = ASCII_ZERO | {4'h0, emit_nib};
               {cur_line_d, cur_col_d} = cur_adv;
            end
            if (step_q == '0) state_d = ST_NEWLINE;
         end

         ST_NEWLINE: begin
            cur_line_d = next_line(cur_line_q);
            cur_col_d  = 7'd0;
            state_d    = ST_IDLE;
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK_25M or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q    <= ST_IDLE;
         err_q      <= ERR_OK;
         sp_q       <= 4'd0;
         entry_q    <= '0;
         cnt_q      <= '0;
         for (int i = 0; i < DEPTH; i++) stack_q[i] <= '0;
         opa_q      <= '0;
         opb_q      <= '0;
         res_q      <= '0;
         carry_q    <= 1'b0;
         sub_q      <= 1'b0;
         step_q     <= '0;
         started_q  <= 1'b0;
         cur_line_q <= 5'd0;
         cur_col_q  <= 7'd0;
         line_q     <= 5'd0;
         char_q     <= 7'd0;
         glyph_q    <= 8'd0;
         latch_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         err_q      <= err_d;
         sp_q       <= sp_d;
         entry_q    <= entry_d;
         cnt_q      <= cnt_d;
         stack_q    <= stack_d;
         opa_q      <= opa_d;
         opb_q      <= opb_d;
         res_q      <= res_d;
         carry_q    <= carry_d;
         sub_q      <= sub_d;
         step_q     <= step_d;
         started_q  <= started_d;
         cur_line_q <= cur_line_d;
         cur_col_q  <= cur_col_d;
         line_q     <= line_d;
         char_q     <= char_d;
         glyph_q    <= glyph_d;
         latch_q    <= latch_d;
      end
   end

   assign Key_Ready = (state_q == ST_IDLE);
   assign Line      = line_q;
   assign Character = char_q;
   assign Glyph     = glyph_q;
   assign Latch     = latch_q;
   assign Err_Code  = err_q;
   assign Depth     = sp_q;

endmodule

// File: tb/tb_rpn_sequencer.sv
// Scoreboard bench for rpn_sequencer: expected VGA writes are queued as keys
// are issued and a monitor compares every Latch. Narrow screen exercises wraps.
module tb_rpn_sequencer;

   localparam int COLS_T = 8;
   localparam int ROWS_T = 8;

   logic       CLK_25M   = 1'b0;
   logic       Reset_n   = 1'b0;
   logic       Key_Valid = 1'b0;
   logic [7:0] Key_Code  = 8'h00;
   logic       Key_Ext   = 1'b0;
   logic       Key_Ready;
   logic [4:0] Line;
   logic [6:0] Character;
   logic [7:0] Glyph;
   logic       Latch;
   logic [1:0] Err_Code;
   logic [3:0] Depth;

   always #20 CLK_25M = ~CLK_25M;

   rpn_sequencer #(.DEPTH(8), .DIGITS(8), .COLS(COLS_T), .ROWS(ROWS_T)) dut (
      .CLK_25M   (CLK_25M),
      .Reset_n   (Reset_n),
      .Key_Valid (Key_Valid),
      .Key_Code  (Key_Code),
      .Key_Ext   (Key_Ext),
      .Key_Ready (Key_Ready),
      .Line      (Line),
      .Character (Character),
      .Glyph     (Glyph),
      .Latch     (Latch),
      .Err_Code  (Err_Code),
      .Depth     (Depth)
   );

   int          checks = 0;
   int          errors = 0;
   logic [19:0] exp_q[$];
   logic [19:0] exp_w;
   int          m_line = 0;
   int          m_col  = 0;
   int          lat;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0d required %0d", name, act, req);
      end
   endtask

   // expected write at the model cursor, cursor then advances with wrap
   task automatic exp_glyph(input logic [7:0] g);
      exp_q.push_back({5'(m_line), 7'(m_col), g});
      if (m_col == COLS_T - 1) begin
         m_col  = 0;
         m_line = (m_line == ROWS_T - 1) ? 0 : m_line + 1;
      end else begin
         m_col++;
      end
   endtask

   task automatic exp_qmark();
      exp_q.push_back({5'(m_line), 7'(m_col), 8'h3F});
   endtask

   task automatic exp_space();
      if (m_col > 0) m_col--;
      exp_q.push_back({5'(m_line), 7'(m_col), 8'h20});
   endtask

   task automatic exp_newline();
      m_col  = 0;
      m_line = (m_line == ROWS_T - 1) ? 0 : m_line + 1;
   endtask

   task automatic send_key(input logic [7:0] c, input logic e);
      int n;
      n = 0;
      @(negedge CLK_25M);
      Key_Valid = 1'b1;
      Key_Code  = c;
      Key_Ext   = e;
      while (!Key_Ready && n < 200) begin
         @(negedge CLK_25M);
         n++;
      end
      if (!Key_Ready) begin
         checks++;
         errors++;
         $display("FAIL key_accept_timeout: code %h not accepted, required acceptance", c);
      end
      @(negedge CLK_25M);
      Key_Valid = 1'b0;
   endtask

   task automatic wait_idle(output int n);
      n = 0;
      while (!Key_Ready && n < 200) begin
         @(negedge CLK_25M);
         n++;
      end
      if (!Key_Ready) begin
         checks++;
         errors++;
         $display("FAIL idle_timeout: Key_Ready stayed 0, required 1");
      end
   endtask

   task automatic press(input logic [7:0] c, input logic e);
      int n;
      send_key(c, e);
      wait_idle(n);
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_line"},  Line, 0);
      check({tag, "_char"},  Character, 0);
      check({tag, "_glyph"}, Glyph, 0);
      check({tag, "_latch"}, Latch, 0);
      check({tag, "_err"},   Err_Code, 0);
      check({tag, "_depth"}, Depth, 0);
      check({tag, "_ready"}, Key_Ready, 1);
   endtask

   always @(negedge CLK_25M) begin
      if (Latch === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL write_unexpected: line %0d col %0d glyph %h, required no write",
                     Line, Character, Glyph);
         end else begin
            exp_w = exp_q.pop_front();
            if ({Line, Character, Glyph} !== exp_w) begin
               errors++;
               $display("FAIL write: got line %0d col %0d glyph %h, required line %0d col %0d glyph %h",
                        Line, Character, Glyph, exp_w[19:15], exp_w[14:8], exp_w[7:0]);
            end
         end
      end
   end

   initial begin
      repeat (3) @(negedge CLK_25M);
      check_idle_outputs("reset");
      Reset_n = 1'b1;

      // 12 Enter 34 + -> 46 on the line after the operator
      exp_glyph(8'h31); press(8'h16, 1'b0);
      exp_glyph(8'h32); press(8'h1E, 1'b0);
      exp_newline();    press(8'h5A, 1'b0);
      exp_glyph(8'h33); press(8'h26, 1'b0);
      exp_glyph(8'h34); press(8'h25, 1'b0);
      exp_newline(); exp_glyph(8'h34); exp_glyph(8'h36); exp_newline();
      send_key(8'h79, 1'b0);
      wait_idle(lat);
      check("op_latency", lat, 17);
      check("add_depth", Depth, 1);
      check("add_err", Err_Code, 0);

      // 99999999 Enter 1 + -> 0 with carry; digit row wraps, line wraps to 0
      exp_newline(); press(8'h76, 1'b0);
      for (int i = 0; i < 8; i++) begin
         exp_glyph(8'h39); press(8'h46, 1'b0);
      end
      press(8'h46, 1'b0);
      exp_newline();    press(8'h5A, 1'b0);
      exp_glyph(8'h31); press(8'h16, 1'b0);
      exp_newline(); exp_glyph(8'h30); exp_newline();
      press(8'h79, 1'b0);
      check("carry_err", Err_Code, 3);
      check("carry_depth", Depth, 1);

      // 5 Enter 7 - -> 99999998 with borrow
      exp_newline();    press(8'h76, 1'b0);
      exp_glyph(8'h35); press(8'h2E, 1'b0);
      exp_newline();    press(8'h5A, 1'b0);
      exp_glyph(8'h37); press(8'h3D, 1'b0);
      exp_newline();
      for (int i = 0; i < 7; i++) exp_glyph(8'h39);
      exp_glyph(8'h38);
      exp_newline();
      press(8'h7B, 1'b0);
      check("borrow_err", Err_Code, 3);
      check("borrow_depth", Depth, 1);

      // 42 Enter 17 - (main-row minus) -> 25, no borrow
      exp_newline();    press(8'h76, 1'b0);
      exp_glyph(8'h34); press(8'h25, 1'b0);
      exp_glyph(8'h32); press(8'h1E, 1'b0);
      exp_newline();    press(8'h5A, 1'b0);
      exp_glyph(8'h31); press(8'h16, 1'b0);
      exp_glyph(8'h37); press(8'h3D, 1'b0);
      exp_newline(); exp_glyph(8'h32); exp_glyph(8'h35); exp_newline();
      press(8'h4E, 1'b0);
      check("sub_err", Err_Code, 0);
      check("sub_depth", Depth, 1);

      // nine pushes: the ninth reports stack full
      exp_newline(); press(8'h76, 1'b0);
      for (int i = 1; i <= 9; i++) begin
         exp_glyph(8'h31); press(8'h16, 1'b0);
         exp_newline();    press(8'h5A, 1'b0);
         if (i == 8) check("push8_err", Err_Code, 0);
      end
      check("full_err", Err_Code, 1);
      check("full_depth", Depth, 8);

      // single operand then '+' (0x55) -> '?', underflow
      exp_newline();    press(8'h76, 1'b0);
      exp_glyph(8'h31); press(8'h16, 1'b0);
      exp_newline();    press(8'h5A, 1'b0);
      exp_qmark(); exp_newline();
      press(8'h55, 1'b0);
      check("under_err", Err_Code, 2);
      check("under_depth", Depth, 1);

      // 12 then three backspaces; unknown and extended keys are ignored
      exp_newline();    press(8'h76, 1'b0);
      exp_glyph(8'h31); press(8'h16, 1'b0);
      exp_glyph(8'h32); press(8'h1E, 1'b0);
      exp_space();      press(8'h66, 1'b0);
      exp_space();      press(8'h66, 1'b0);
      press(8'h66, 1'b0);
      press(8'h1C, 1'b0);
      press(8'h16, 1'b1);
      check("ignore_depth", Depth, 0);
      check("ignore_err", Err_Code, 0);

      // reset during EMIT of 5+3: no write of '8' may follow
      exp_newline();    press(8'h76, 1'b0);
      exp_glyph(8'h35); press(8'h2E, 1'b0);
      exp_newline();    press(8'h5A, 1'b0);
      exp_glyph(8'h33); press(8'h26, 1'b0);
      send_key(8'h79, 1'b0);
      repeat (10) @(negedge CLK_25M);
      check("emit_busy", Key_Ready, 0);
      #5 Reset_n = 1'b0;
      #1 check_idle_outputs("async_reset");
      @(negedge CLK_25M);
      check_idle_outputs("held_reset");
      Reset_n = 1'b1;
      m_line  = 0;
      m_col   = 0;
      repeat (20) @(negedge CLK_25M);
      exp_glyph(8'h37); press(8'h3D, 1'b0);
      check("post_reset_depth", Depth, 0);

      repeat (5) @(negedge CLK_25M);
      check("queue_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
